join_number: RTL and testbench



---
 rtl/calc_pkg.sv | 19 +
 rtl/join_number_if.sv | 28 ++
 rtl/mul10_add.sv | 17 +
 rtl/join_number.sv | 145 ++++++++++++++
 tb/tb_join_number.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: digit/number types, conversion constants
// and the state encoding of the BCD-to-binary joiner.
package calc_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int NUMBER_W   = 14;
    localparam int DIGIT_MAX  = 9;

    typedef logic [3:0]  digit_t;
    typedef logic [13:0] number_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } join_state_e;

endpackage

// File: rtl/join_number_if.sv
// Handshake bundle between keypad/display logic, the BCD joiner and the
// calculator datapath.
//   digits_i/valid_i/ready_o : BCD digit input channel ([3]=thousands)
//   number_o/error_o/valid_o/ready_i : binary result channel
// master = producer/consumer side, slave = the converter.
interface join_number_if #(
    parameter int NUM_DIGITS = calc_pkg::NUM_DIGITS,
    parameter int DIGIT_W    = calc_pkg::DIGIT_W,
    parameter int NUMBER_W   = calc_pkg::NUMBER_W
);
    logic [DIGIT_W-1:0]  digits_i [NUM_DIGITS];
    logic                valid_i;
    logic                ready_o;
    logic [NUMBER_W-1:0] number_o;
    logic                error_o;
    logic                valid_o;
    logic                ready_i;

    modport master (
        output digits_i, valid_i, ready_i,
        input  ready_o, number_o, error_o, valid_o
    );

    modport slave (
        input  digits_i, valid_i, ready_i,
        output ready_o, number_o, error_o, valid_o
    );
endinterface

// File: rtl/mul10_add.sv
// Combinational decimal fold step: sum_o = acc_i*10 + digit_i, truncated
// to NUMBER_W. The x10 is built from two shifts so no multiplier is needed.
//   acc_i   : running binary value
//   digit_i : next decimal digit (unsigned)
//   sum_o   : folded value
module mul10_add #(
    parameter int NUMBER_W = calc_pkg::NUMBER_W,
    parameter int DIGIT_W  = calc_pkg::DIGIT_W
) (
    input  logic [NUMBER_W-1:0] acc_i,
    input  logic [DIGIT_W-1:0]  digit_i,
    output logic [NUMBER_W-1:0] sum_o
);

    assign sum_o = (acc_i << 2'd3) + (acc_i << 1'd1) + NUMBER_W'(digit_i);

endmodule

// File: rtl/join_number.sv
// Sequential BCD-to-binary converter. Accepts NUM_DIGITS BCD digits over a
// valid/ready handshake, folds them most-significant first at one digit per
// cycle and presents the binary result plus an invalid-digit flag over a
// second valid/ready handshake.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : join_number_if.slave (digit input and result output channels)
module join_number #(
    parameter int NUM_DIGITS = calc_pkg::NUM_DIGITS,
    parameter int DIGIT_W    = calc_pkg::DIGIT_W,
    parameter int NUMBER_W   = calc_pkg::NUMBER_W
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    join_number_if.slave  bus
);
    import calc_pkg::*;

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    join_state_e         state_r;
    join_state_e         state_next_s;
    logic [DIGIT_W-1:0]  digits_r [NUM_DIGITS];
    logic [NUMBER_W-1:0] acc_r;
    logic [NUMBER_W-1:0] acc_next_s;
    logic [NUMBER_W-1:0] number_r;
    logic [IDX_W-1:0]    idx_r;
    logic                error_r;
    logic                valid_r;
    logic                bad_digit_s;
    logic                accept_s;
    logic                last_digit_s;

    // Flag the incoming digit set if any digit lies outside 0..9
    always_comb begin
        bad_digit_s = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bad_digit_s = bad_digit_s | (bus.digits_i[i] > DIGIT_W'(DIGIT_MAX));
        end
    end

    assign accept_s     = bus.valid_i && (state_r == IDLE);
    assign last_digit_s = (idx_r == {IDX_W{1'b0}});

    mul10_add #(
        .NUMBER_W (NUMBER_W),
        .DIGIT_W  (DIGIT_W)
    ) u_mul10_add (
        .acc_i   (acc_r),
        .digit_i (digits_r[idx_r]),
        .sum_o   (acc_next_s)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: an invalid digit skips straight to DONE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = bad_digit_s ? DONE : CONVERT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CONVERT: begin
                if (last_digit_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CONVERT;
                end
            end
            DONE: begin
                if (bus.ready_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath: digit capture, accumulation and registered result outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits_r[i] <= {DIGIT_W{1'b0}};
            end
            acc_r    <= {NUMBER_W{1'b0}};
            idx_r    <= {IDX_W{1'b0}};
            number_r <= {NUMBER_W{1'b0}};
            error_r  <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        digits_r <= bus.digits_i;
                        acc_r    <= {NUMBER_W{1'b0}};
                        idx_r    <= IDX_LAST;
                        error_r  <= bad_digit_s;
                        if (bad_digit_s) begin
                            number_r <= {NUMBER_W{1'b0}};
                            valid_r  <= 1'b1;
                        end
                    end
                end
                CONVERT: begin
                    acc_r <= acc_next_s;
                    if (last_digit_s) begin
                        number_r <= acc_next_s;
                        valid_r  <= 1'b1;
                    end else begin
                        idx_r <= idx_r - 1'b1;
                    end
                end
                DONE: begin
                    // number_r/error_r stay as they are; only valid drops
                    if (bus.ready_i) begin
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_o  = (state_r == IDLE);
    assign bus.number_o = number_r;
    assign bus.error_o  = error_r;
    assign bus.valid_o  = valid_r;

endmodule

// File: tb/tb_join_number.sv
// Directed self-checking bench for join_number: conversions, extremes,
// invalid digits, backpressure, mid-conversion reset and a random stream.
module tb_join_number;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    join_number_if bus ();

    join_number dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_digits(input int d3, input int d2, input int d1, input int d0);
        bus.digits_i[3] = d3[3:0];
        bus.digits_i[2] = d2[3:0];
        bus.digits_i[1] = d1[3:0];
        bus.digits_i[0] = d0[3:0];
    endtask

    // Called at a negedge with ready_o=1 and ready_i=1. Counts the
    // post-accept cycles with valid_o low (lat) and with ready_o low (rlow).
    task automatic run_one(input string tag, input int d3, input int d2, input int d1,
                           input int d0, input int exp_num, input int exp_err,
                           input int exp_lat, input int exp_rlow);
        int lat;
        int rlow;
        lat  = -1;
        rlow = 0;
        set_digits(d3, d2, d1, d0);
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (bus.ready_o) break;
            rlow++;
            if (bus.valid_o && lat < 0) begin
                lat = cyc - 1;
                check({tag, "_num"}, 32'(bus.number_o), 32'(exp_num));
                check({tag, "_err"}, 32'(bus.error_o), 32'(exp_err));
            end
            @(negedge clk);
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rlow"}, 32'(rlow), 32'(exp_rlow));
        check({tag, "_vdrop"}, 32'(bus.valid_o), 32'd0);
    endtask

    int exp_q[$];
    int sent;
    int got_n;
    int exp_v;
    int wait_cnt;
    int r3, r2, r1, r0;

    initial begin
        rst_n       = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        set_digits(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ready_o), 32'd1);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_num", 32'(bus.number_o), 32'd0);
        check("rst_err", 32'(bus.error_o), 32'd0);
        rst_n = 1'b1;
        bus.ready_i = 1'b1;
        @(negedge clk);

        // Basic and range extremes
        run_one("t1234", 1, 2, 3, 4, 1234, 0, 4, 5);
        run_one("t9999", 9, 9, 9, 9, 9999, 0, 4, 5);
        run_one("t0000", 0, 0, 0, 0, 0, 0, 4, 5);
        run_one("t0007", 0, 0, 0, 7, 7, 0, 4, 5);
        run_one("t1000", 1, 0, 0, 0, 1000, 0, 4, 5);

        // Invalid digit: result in the cycle right after accept
        run_one("tbad", 1, 2, 10, 4, 0, 1, 0, 1);
        run_one("t0042", 0, 0, 4, 2, 42, 0, 4, 5);

        // Backpressure with ignored valid_i during CONVERT/DONE
        bus.ready_i = 1'b0;
        set_digits(3, 0, 5, 1);
        bus.valid_i = 1'b1;
        @(negedge clk);
        set_digits(9, 9, 9, 9);
        wait_cnt = 0;
        while (!bus.valid_o && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("bp_wait", 32'(wait_cnt), 32'd4);
        check("bp_num0", 32'(bus.number_o), 32'd3051);
        check("bp_err0", 32'(bus.error_o), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.valid_o), 32'd1);
            check("bp_num", 32'(bus.number_o), 32'd3051);
            check("bp_err", 32'(bus.error_o), 32'd0);
            check("bp_ready", 32'(bus.ready_o), 32'd0);
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        @(negedge clk);
        check("bp_hs_ready", 32'(bus.ready_o), 32'd1);
        check("bp_hs_valid", 32'(bus.valid_o), 32'd0);
        run_one("t0001", 0, 0, 0, 1, 1, 0, 4, 5);

        // Reset in the second CONVERT cycle
        set_digits(1, 2, 3, 4);
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("ar_ready", 32'(bus.ready_o), 32'd1);
        check("ar_valid", 32'(bus.valid_o), 32'd0);
        check("ar_num", 32'(bus.number_o), 32'd0);
        check("ar_err", 32'(bus.error_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_one("t5678", 5, 6, 7, 8, 5678, 0, 4, 5);

        // Random stream with random backpressure, scoreboarded in order
        sent  = 0;
        got_n = 0;
        for (int cyc = 0; cyc < 40000 && got_n < 1000; cyc++) begin
            @(negedge clk);
            bus.ready_i = 1'($urandom_range(0, 1));
            if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                r3 = $urandom_range(0, 9);
                r2 = $urandom_range(0, 9);
                r1 = $urandom_range(0, 9);
                r0 = $urandom_range(0, 9);
                set_digits(r3, r2, r1, r0);
                bus.valid_i = 1'b1;
            end else begin
                bus.valid_i = 1'b0;
            end
            if (bus.valid_o && bus.ready_i) begin
                if (exp_q.size() == 0) begin
                    check("rnd_extra", 32'(bus.number_o), 32'hFFFF_FFFF);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("rnd_num", 32'(bus.number_o), 32'(exp_v));
                    check("rnd_err", 32'(bus.error_o), 32'd0);
                end
                got_n++;
            end
            if (bus.valid_i && bus.ready_o) begin
                exp_q.push_back(r3 * 1000 + r2 * 100 + r1 * 10 + r0);
                sent++;
            end
        end
        bus.valid_i = 1'b0;
        check("rnd_count", 32'(got_n), 32'd1000);
        check("rnd_left", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
